// File: rtl/operand_loader.sv
// Push-button driven operand/operation capture for the ALU: synchronised button edges latch
// the switch value into per-slot registers, and a valid/ack handshake hands the full set over.
module operand_loader #(
   parameter int NB_DATA    = 8,
   parameter int NB_OP      = 6,
   parameter int N_OPERANDS = 2,
   parameter int NB_SYNC    = 2
) (
   input  logic                          i_clock,
   input  logic                          i_reset,
   input  logic [N_OPERANDS:0]           i_buttons,
   input  logic [NB_DATA-1:0]            i_switches,
   input  logic                          i_ack,
   output logic [N_OPERANDS*NB_DATA-1:0] o_operands,
   output logic [NB_OP-1:0]              o_operation,
   output logic [N_OPERANDS:0]           o_loaded_mask,
   output logic                          o_valid
);
   localparam int N_SLOTS = N_OPERANDS + 1;

   logic [N_SLOTS-1:0] sync_reg [NB_SYNC];
   logic [N_SLOTS-1:0] prev_reg;
   logic [N_SLOTS-1:0] press;
   logic [N_SLOTS-1:0] mask_reg, mask_next;
   logic               valid_reg, valid_next;
   logic               consume;
   logic [NB_OP-1:0]   operation_reg;

   genvar gi;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         for (int i = 0; i < NB_SYNC; i++) sync_reg[i] <= '0;
         prev_reg <= '0;
      end else begin
         sync_reg[0] <= i_buttons;
         for (int i = 1; i < NB_SYNC; i++) sync_reg[i] <= sync_reg[i-1];
         prev_reg <= sync_reg[NB_SYNC-1];
      end
   end

   // One pulse per press: a held button stays high in both the last sync stage and prev.
   assign press = sync_reg[NB_SYNC-1] & ~prev_reg;

   // An ack only counts while a complete set is on offer; any press in that same cycle
   // starts the next set rather than being lost.
   always_comb begin
      consume    = valid_reg & i_ack;
      mask_next  = mask_reg | press;
      valid_next = &mask_reg;
      if (consume) begin
         mask_next  = press;
         valid_next = 1'b0;
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         mask_reg      <= '0;
         valid_reg     <= 1'b0;
         operation_reg <= '0;
      end else begin
         mask_reg  <= mask_next;
         valid_reg <= valid_next;
         if (press[N_OPERANDS]) operation_reg <= i_switches[NB_OP-1:0];
      end
   end

   for (gi = 0; gi < N_OPERANDS; gi++) begin : g_operand
      logic [NB_DATA-1:0] operand_reg;

      always_ff @(posedge i_clock or posedge i_reset) begin
         if (i_reset)        operand_reg <= '0;
         else if (press[gi]) operand_reg <= i_switches;
      end

      assign o_operands[gi*NB_DATA +: NB_DATA] = operand_reg;
   end

   assign o_operation   = operation_reg;
   assign o_loaded_mask = mask_reg;
   assign o_valid       = valid_reg;

endmodule

// File: tb/tb_operand_loader.sv
// Bench for operand_loader: directed steps from the test plan plus a random phase, all
// checked cycle by cycle against a reference model of the capture/handshake rules.
module tb_operand_loader;
   logic        clk;
   logic        rst;
   logic [2:0]  btn_a;
   logic [7:0]  sw_a;
   logic        ack_a;
   logic [15:0] ops_a;
   logic [5:0]  op_a;
   logic [2:0]  mask_a;
   logic        valid_a;
   logic [4:0]  btn_b;
   logic [15:0] sw_b;
   logic        ack_b;
   logic [63:0] ops_b;
   logic [5:0]  op_b;
   logic [4:0]  mask_b;
   logic        valid_b;

   operand_loader dut_a (
      .i_clock(clk), .i_reset(rst), .i_buttons(btn_a), .i_switches(sw_a), .i_ack(ack_a),
      .o_operands(ops_a), .o_operation(op_a), .o_loaded_mask(mask_a), .o_valid(valid_a)
   );

   operand_loader #(.NB_DATA(16), .N_OPERANDS(4)) dut_b (
      .i_clock(clk), .i_reset(rst), .i_buttons(btn_b), .i_switches(sw_b), .i_ack(ack_b),
      .o_operands(ops_b), .o_operation(op_b), .o_loaded_mask(mask_b), .o_valid(valid_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model, index 0 = default instance, 1 = wide instance
   int          nops_of [2] = '{2, 4};
   logic [4:0]  m_mask  [2];
   logic        m_valid [2];
   logic [15:0] m_opnd  [2][4];
   logic [5:0]  m_op    [2];
   logic [4:0]  m_hist  [2][3];   // button samples taken 1, 2, 3 edges ago

   logic [7:0]  held_val;
   logic [15:0] b_vals [5];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_model(input int d);
      m_mask[d]  = '0;
      m_valid[d] = 1'b0;
      m_op[d]    = '0;
      for (int k = 0; k < 4; k++) m_opnd[d][k] = '0;
      for (int k = 0; k < 3; k++) m_hist[d][k] = '0;
   endtask

   // A press is seen two edges after the button is first sampled high (after a low sample);
   // it is captured at the current edge.
   task automatic model_step(input int d, input logic [4:0] btn, input logic [15:0] sw,
                             input logic ack);
      logic [4:0] pressed;
      logic [4:0] full;
      logic       ready_next;
      int         full_i;
      if (rst) begin
         clear_model(d);
         return;
      end
      full_i  = (1 << (nops_of[d] + 1)) - 1;
      full    = 5'(full_i);
      pressed = m_hist[d][1] & ~m_hist[d][2] & full;
      m_hist[d][2] = m_hist[d][1];
      m_hist[d][1] = m_hist[d][0];
      m_hist[d][0] = btn;
      ready_next = (m_valid[d] && ack) ? 1'b0 : (m_mask[d] == full);
      if (m_valid[d] && ack) m_mask[d] = pressed;
      else                   m_mask[d] = m_mask[d] | pressed;
      for (int k = 0; k < nops_of[d]; k++)
         if (pressed[k]) m_opnd[d][k] = (d == 0) ? {8'h00, sw[7:0]} : sw;
      if (pressed[nops_of[d]]) m_op[d] = sw[5:0];
      m_valid[d] = ready_next;
   endtask

   task automatic check_all();
      check("a.operands", 64'(ops_a), 64'({m_opnd[0][1][7:0], m_opnd[0][0][7:0]}));
      check("a.operation", 64'(op_a), 64'(m_op[0]));
      check("a.mask", 64'(mask_a), 64'(m_mask[0][2:0]));
      check("a.valid", 64'(valid_a), 64'(m_valid[0]));
      check("b.operands", ops_b, {m_opnd[1][3], m_opnd[1][2], m_opnd[1][1], m_opnd[1][0]});
      check("b.operation", 64'(op_b), 64'(m_op[1]));
      check("b.mask", 64'(mask_b), 64'(m_mask[1]));
      check("b.valid", 64'(valid_b), 64'(m_valid[1]));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step(0, {2'b00, btn_a}, {8'h00, sw_a}, ack_a);
      model_step(1, btn_b, sw_b, ack_b);
      #1;
      check_all();
   endtask

   // Button held through the capture edge (third tick), then released.
   task automatic press_a(input int k, input logic [7:0] v);
      btn_a[k] = 1'b1;
      sw_a     = v;
      repeat (3) tick();
      btn_a[k] = 1'b0;
   endtask

   task automatic press_b(input int k, input logic [15:0] v);
      btn_b[k] = 1'b1;
      sw_b     = v;
      repeat (3) tick();
      btn_b[k] = 1'b0;
   endtask

   initial begin
      rst = 1'b1; btn_a = '0; sw_a = '0; ack_a = 1'b0;
      btn_b = '0; sw_b = '0; ack_b = 1'b0;
      clear_model(0);
      clear_model(1);
      repeat (2) tick();
      check("rst.ops", 64'(ops_a), 64'h0);
      check("rst.op", 64'(op_a), 64'h0);
      check("rst.mask", 64'(mask_a), 64'h0);
      check("rst.valid", 64'(valid_a), 64'h0);
      rst = 1'b0;
      tick();

      // first capture latency
      btn_a[0] = 1'b1; sw_a = 8'hFF;
      tick(); tick();
      check("lat.early", 64'(ops_a[7:0]), 64'h0);
      tick();
      check("lat.op0", 64'(ops_a[7:0]), 64'hFF);
      check("lat.mask", 64'(mask_a), 64'h1);
      check("lat.valid", 64'(valid_a), 64'h0);
      btn_a[0] = 1'b0; sw_a = '0;
      tick(); tick();

      // full set
      press_a(0, 8'h0A); tick();
      press_a(1, 8'hF3); tick();
      press_a(2, 8'hE0);
      check("full.mask", 64'(mask_a), 64'h7);
      check("full.valid_late", 64'(valid_a), 64'h0);
      check("full.op", 64'(op_a), 64'h20);
      check("full.ops", 64'(ops_a), 64'hF30A);
      tick();
      check("full.valid", 64'(valid_a), 64'h1);
      tick();

      // held button with switches changing every cycle
      btn_a[1] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         sw_a = 8'($urandom);
         if (i == 2) held_val = sw_a;
         tick();
      end
      check("hold.op1", 64'(ops_a[15:8]), 64'(held_val));
      check("hold.valid", 64'(valid_a), 64'h1);
      btn_a[1] = 1'b0;
      tick(); tick();
      press_a(1, 8'hF3); tick(); tick();

      // ack in READY, then ack while EMPTY
      ack_a = 1'b1; tick(); ack_a = 1'b0;
      check("ack.valid", 64'(valid_a), 64'h0);
      check("ack.mask", 64'(mask_a), 64'h0);
      check("ack.ops", 64'(ops_a), 64'hF30A);
      tick();
      ack_a = 1'b1; tick(); ack_a = 1'b0;
      check("ackempty.mask", 64'(mask_a), 64'h0);
      check("ackempty.ops", 64'(ops_a), 64'hF30A);
      check("ackempty.op", 64'(op_a), 64'h20);

      // ack coinciding with a press while READY
      press_a(0, 8'h0A); tick();
      press_a(1, 8'hF3); tick();
      press_a(2, 8'hE0); tick(); tick();
      check("ackedge.ready", 64'(valid_a), 64'h1);
      btn_a[0] = 1'b1; sw_a = 8'h55;
      tick(); tick();
      ack_a = 1'b1; tick(); ack_a = 1'b0; btn_a[0] = 1'b0;
      check("ackedge.mask", 64'(mask_a), 64'h1);
      check("ackedge.ops", 64'(ops_a), 64'hF355);
      check("ackedge.valid", 64'(valid_a), 64'h0);
      tick(); tick();

      // asynchronous reset mid-cycle while FILLING, button held across reset
      press_a(1, 8'h77); tick();
      check("arst.pre_mask", 64'(mask_a), 64'h3);
      #2 rst = 1'b1;
      #1;
      clear_model(0);
      clear_model(1);
      check("arst.ops", 64'(ops_a), 64'h0);
      check("arst.op", 64'(op_a), 64'h0);
      check("arst.mask", 64'(mask_a), 64'h0);
      check("arst.valid", 64'(valid_a), 64'h0);
      btn_a[2] = 1'b1; sw_a = 8'h3C;
      tick(); tick();
      #2 rst = 1'b0;
      tick(); tick();
      check("arst.no_early", 64'(mask_a), 64'h0);
      tick();
      check("arst.held_edge", 64'(mask_a), 64'h4);
      check("arst.held_op", 64'(op_a), 64'h3C);
      btn_a[2] = 1'b0;
      tick(); tick();

      // wide instance: five slots
      for (int k = 0; k < 5; k++) begin
         b_vals[k] = 16'($urandom);
         press_b(k, b_vals[k]);
         check("wide.not_valid", 64'(valid_b), 64'h0);
         tick();
      end
      check("wide.mask", 64'(mask_b), 64'h1F);
      check("wide.valid", 64'(valid_b), 64'h1);
      check("wide.ops", ops_b, {b_vals[3], b_vals[2], b_vals[1], b_vals[0]});
      check("wide.op", 64'(op_b), 64'(b_vals[4][5:0]));
      ack_b = 1'b1; tick(); ack_b = 1'b0;
      check("wide.ack", 64'(valid_b), 64'h0);

      // random phase
      for (int i = 0; i < 400; i++) begin
         btn_a = 3'($urandom) & 3'($urandom);
         sw_a  = 8'($urandom);
         ack_a = ($urandom_range(0, 3) == 0);
         btn_b = 5'($urandom) & 5'($urandom);
         sw_b  = 16'($urandom);
         ack_b = ($urandom_range(0, 3) == 0);
         if (i == 200) begin
            #2 rst = 1'b1;
            #1;
            clear_model(0);
            clear_model(1);
            check_all();
            tick();
            #2 rst = 1'b0;
         end
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
